// File: rtl/tick_timer_pkg.sv
// Shared constants and width helper for the tick timer.
package tick_timer_pkg;

    localparam int SIM_CLK_DIV = 4;
    localparam int HW_CLK_DIV  = 50000000;

    // Prescaler count width: clog2(x), but never narrower than one bit.
    function automatic int pre_w(input int x);
        return (x <= 2) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by CLK_DIV into a registered one-cycle tick; en freezes, tick_sync restarts phase.
module tick_prescaler
    import tick_timer_pkg::*;
#(
    parameter int CLK_DIV = HW_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic tick_sync,
    output logic tick
);

    localparam int               PRE_W = pre_w(CLK_DIV);
    localparam logic [PRE_W-1:0] TERM  = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] cnt;

    // With CLK_DIV=1 TERM is 0, so the count never leaves 0 and every enabled edge ticks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (tick_sync) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (cnt == TERM) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + PRE_W'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/tick_timer.sv
// Timebase plus N_CH loadable countdown channels, each with a one-cycle expiry pulse.
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter int CLK_DIV = HW_CLK_DIV,
    parameter int CNT_W   = 8,
    parameter int N_CH    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  tick_sync,
    output logic                  tick,
    input  logic [N_CH-1:0]       ld,
    input  logic [N_CH*CNT_W-1:0] ld_val,
    output logic [N_CH*CNT_W-1:0] remain,
    output logic [N_CH-1:0]       busy,
    output logic [N_CH-1:0]       done
);

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_pre (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .tick_sync (tick_sync),
        .tick      (tick)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic             done_q;

        // A load wins over a same-cycle tick, so a reload never loses its first tick unit.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                done_q <= 1'b0;
            end else if (ld[i]) begin
                cnt_q  <= ld_val[i*CNT_W +: CNT_W];
                done_q <= 1'b0;
            end else if (tick && (cnt_q != '0)) begin
                cnt_q  <= cnt_q - CNT_W'(1);
                done_q <= (cnt_q == CNT_W'(1));
            end else begin
                done_q <= 1'b0;
            end
        end

        assign remain[i*CNT_W +: CNT_W] = cnt_q;
        assign busy[i]                  = |cnt_q;
        assign done[i]                  = done_q;
    end

endmodule

// File: doc/tick_timer.md
Name: tick_timer

Overview:
- Parametrised timebase plus multi-channel countdown timer. Successor to the fixed one-second enable generator.
- The prescaler divides clk by a compile-time CLK_DIV into a one-cycle tick.
- N_CH independent loadable down-counters consume the tick and each signals expiry with a done pulse.
- Sits between the system clock and the traffic-light phase FSMs; one channel per phase timer (main road, side road, pedestrian, ...).

Parameters:
- CLK_DIV, 50000000: clk cycles per tick (≥1); sim benches use 4.
- CNT_W, 8: width of each channel counter (tick units).
- N_CH, 2: number of countdown channels (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  run enable; 0 freezes the prescaler and suppresses ticks
- tick_sync  in  1  restart prescaler phase (count to 0)
- tick  out  1  registered one-cycle pulse every CLK_DIV enabled cycles
- ld  in  N_CH  per-channel load strobe
- ld_val  in  N_CH*CNT_W  load values; channel i at [i*CNT_W +: CNT_W]
- remain  out  N_CH*CNT_W  current channel counts, same packing
- busy  out  N_CH  remain[i] != 0 (combinational from the register)
- done  out  N_CH  registered one-cycle expiry pulse per channel

Behaviour:
- Reset (rst_n=0 at posedge): prescaler count=0, tick=0, all remain=0, done=0. busy=0 follows. Reset overrides all inputs, mid-count included.
- Prescaler:
  - Width PRE_W = max(1, clog2(CLK_DIV)).
  - Priority: tick_sync > en.
  - tick_sync=1: count←0, tick←0.
  - Else if en=1: count==CLK_DIV-1 → count←0, tick←1; otherwise count←count+1, tick←0.
  - Else (en=0): count holds, tick←0.
- tick timing:
  - First tick is high in the cycle after the CLK_DIV-th enabled edge following reset or sync.
  - Period is exactly CLK_DIV enabled cycles.
  - en low for k cycles stretches the period by k.
- CLK_DIV=1: tick=1 on every cycle following an enabled edge. No terminal compare beyond count==0.
- Channel i, evaluated each posedge; priority ld > tick decrement:
  - ld[i]=1: remain[i]←ld_val[i], done[i]←0. A simultaneous tick is ignored for that channel.
  - Else if tick=1 and remain[i]!=0: remain[i]←remain[i]-1. done[i]←1 iff remain[i]==1.
  - Else: remain holds, done[i]←0.
- Countdown latency:
  - remain decrements on the edge where tick is high; the new value is visible the next cycle.
  - done rises together with remain reaching 0.
  - A load of value V expires after exactly V ticks.
- Boundary cases:
  - Load of 0: remain=0, busy=0, no done pulse ever.
  - remain=0 with tick: no wrap, no done.
  - Load of all-ones (2^CNT_W-1): counts the full range, no overflow.
  - Reload while busy: the new value replaces the old; no done for the abandoned count.
  - Reload on the done cycle is legal; that done pulse still appears once.
  - en=0: no ticks, so channels freeze; ld still works.
  - tick_sync does not touch the channels.
- Channels are independent. Any mix of simultaneous ld/done across channels is allowed.

Decomposition:
- Package tick_timer_pkg holds:
  - default constants SIM_CLK_DIV=4 and HW_CLK_DIV=50000000;
  - a function for PRE_W = max(1, clog2(x)).
- Sub-module tick_prescaler (CLK_DIV → tick, with en/tick_sync).
- Channels are generated inline (generate loop) in tick_timer.

Test Plan:
- Reset/idle: CLK_DIV=4, rst_n low 3 cycles then high, en=1 → tick at cycles 4, 8, 12 after release; remain=0, busy=0, done=0 throughout.
- Basic countdown: ld[0] with value 3 → busy[0]=1; remain 3→2→1→0 on successive ticks. done[0] pulses exactly once, in the cycle remain becomes 0 (12 cycles after load when tick is aligned).
- Priority and zero load:
  - ld[1] value 5 asserted in a tick cycle → remain[1]=5, not 4.
  - ld value 0 → busy=0, no done after 20 cycles.
- en/tick_sync:
  - en low for 6 cycles mid-period → next tick delayed by 6; remain frozen.
  - tick_sync one cycle before a due tick → that tick suppressed, next tick 4 cycles later.
- Reload and reset mid-operation:
  - Reload ch0 with 2 while remain=1 → no done; expiry 2 ticks later.
  - rst_n low while remain=7 → remain=0, tick=0, done=0 next cycle.
- Multi-channel plus corner values: N_CH=3, CNT_W=4, CLK_DIV=1; load 15, 1, 0 simultaneously → done[1] after 1 tick, done[0] after 15, done[2] never.
